// File: rtl/mips32_prog_loader.sv
// Boot-time program loader for pipe_MIPS32: unpacks a framed byte stream into 32-bit
// words, writes them into CPU Mem, verifies an XOR checksum and only then releases the CPU.
module mips32_prog_loader #(
    parameter int unsigned ADDR_W    = 10,
    parameter int unsigned BASE_ADDR = 0,
    parameter int unsigned MAX_WORDS = 1024
) (
    input  logic              clk1,
    input  logic              rst_n,
    input  logic [7:0]        in_data,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              restart,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic              cpu_run,
    output logic              load_done,
    output logic              load_err
);

    typedef enum logic [2:0] {
        S_IDLE, S_LEN_HI, S_LEN_LO, S_DATA, S_CSUM, S_DONE, S_ERROR
    } state_t;

    localparam logic [7:0] SYNC_BYTE = 8'hA5;

    state_t              r_state;
    state_t              w_next_state;
    logic [15:0]         r_len;
    logic [7:0]          r_csum;
    logic [23:0]         r_word;
    logic [1:0]          r_byte_idx;
    logic [15:0]         r_word_idx;
    logic                r_mem_we;
    logic [ADDR_W-1:0]   r_mem_addr;
    logic [31:0]         r_mem_wdata;

    logic                w_accept;
    logic [15:0]         w_len;
    logic                w_last_word;

    assign w_accept    = in_valid && in_ready;
    assign w_len       = {r_len[15:8], in_data};
    assign w_last_word = (r_word_idx == (r_len - 16'd1));

    // NOTE: every signal gets a default before the case so no path can infer a latch.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE:   if (w_accept && in_data == SYNC_BYTE) w_next_state = S_LEN_HI;
            S_LEN_HI: if (w_accept) w_next_state = S_LEN_LO;
            S_LEN_LO: begin
                if (w_accept) begin
                    if ({16'd0, w_len} > MAX_WORDS) w_next_state = S_ERROR;
                    else if (w_len == 16'd0)       w_next_state = S_CSUM;
                    else                           w_next_state = S_DATA;
                end
            end
            S_DATA:   if (w_accept && r_byte_idx == 2'd3 && w_last_word) w_next_state = S_CSUM;
            S_CSUM:   if (w_accept) w_next_state = (in_data == r_csum) ? S_DONE : S_ERROR;
            S_DONE,
            S_ERROR:  if (restart) w_next_state = S_IDLE;
            default:  w_next_state = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk1 or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_next_state;
    end

    always_ff @(posedge clk1 or negedge rst_n) begin
        if (!rst_n) begin
            r_len       <= '0;
            r_csum      <= '0;
            r_word      <= '0;
            r_byte_idx  <= '0;
            r_word_idx  <= '0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
        end else begin
            r_mem_we <= 1'b0;
            if (w_accept) begin
                case (r_state)
                    S_LEN_HI: begin
                        r_len[15:8] <= in_data;
                        r_csum      <= in_data;
                    end
                    S_LEN_LO: begin
                        r_len[7:0] <= in_data;
                        r_csum     <= r_csum ^ in_data;
                        r_byte_idx <= '0;
                        r_word_idx <= '0;
                    end
                    S_DATA: begin
                        r_csum     <= r_csum ^ in_data;
                        r_word     <= {r_word[15:0], in_data};
                        r_byte_idx <= r_byte_idx + 2'd1;
                        if (r_byte_idx == 2'd3) begin
                            // Completed word: one-cycle strobe, address follows word index.
                            r_mem_we    <= 1'b1;
                            r_mem_addr  <= ADDR_W'(BASE_ADDR) + r_word_idx[ADDR_W-1:0];
                            r_mem_wdata <= {r_word, in_data};
                            if (!w_last_word) r_word_idx <= r_word_idx + 16'd1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign in_ready  = (r_state != S_DONE) && (r_state != S_ERROR);
    assign load_done = (r_state == S_DONE);
    assign cpu_run   = (r_state == S_DONE);
    assign load_err  = (r_state == S_ERROR);
    assign mem_we    = r_mem_we;
    assign mem_addr  = r_mem_addr;
    assign mem_wdata = r_mem_wdata;

endmodule
